// File: rtl/line_pkg.sv
// Shared definitions for the line FIFO producer and the line_packer sink.
package line_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int WORD_BYTES_DEF  = 4;
    localparam int LINE_BYTES_DEF  = 640;
    localparam int FRAME_LINES_DEF = 480;
    localparam int STARVE_CYC_DEF  = 1024;

endpackage

// File: rtl/line_pos_cnt.sv
// Byte-in-line and line-in-frame position counters with first/last decode.
module line_pos_cnt #(
    parameter int WORD_BYTES  = line_pkg::WORD_BYTES_DEF,
    parameter int LINE_BYTES  = line_pkg::LINE_BYTES_DEF,
    parameter int FRAME_LINES = line_pkg::FRAME_LINES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic adv_i,
    output logic sol_o,
    output logic eol_o,
    output logic sof_o,
    output logic eof_o
);

    localparam int BW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - WORD_BYTES);
    localparam logic [BW-1:0] BYTE_STEP = BW'(WORD_BYTES);
    localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);

    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;

    // Advance one word per load; wrap bytes at line end, lines at frame end.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        line_cnt_d = line_cnt_q;
        if (clr_i) begin
            byte_cnt_d = '0;
            line_cnt_d = '0;
        end else if (adv_i) begin
            if (byte_cnt_q == BYTE_LAST) begin
                byte_cnt_d = '0;
                line_cnt_d = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + LW'(1);
            end else begin
                byte_cnt_d = byte_cnt_q + BYTE_STEP;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign sol_o = (byte_cnt_q == '0);
    assign eol_o = (byte_cnt_q == BYTE_LAST);
    assign sof_o = sol_o && (line_cnt_q == '0);
    assign eof_o = eol_o && (line_cnt_q == LINE_LAST);

endmodule

// File: rtl/line_packer.sv
// Pops bytes from a FWFT line FIFO, packs them little-endian into words and
// streams them out with line/frame position tags.
module line_packer
    import line_pkg::*;
#(
    parameter int WORD_BYTES  = WORD_BYTES_DEF,
    parameter int LINE_BYTES  = LINE_BYTES_DEF,
    parameter int FRAME_LINES = FRAME_LINES_DEF,
    parameter int STARVE_CYC  = STARVE_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [7:0]              fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sol,
    output logic                    out_eol,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic                    busy,
    output logic                    done,
    output logic                    starve_err
);

    localparam int SW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CW = $clog2(STARVE_CYC + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(WORD_BYTES - 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_CYC);

    state_e                  state_q, state_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [8*WORD_BYTES-1:0] pack_q, pack_d;
    logic [8*WORD_BYTES-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
    logic                    done_q, done_d;
    logic [CW-1:0]           starve_cnt_q, starve_cnt_d;
    logic                    starve_err_q, starve_err_d;

    logic start_ok, accept, pop, load, mid_line;
    logic pos_sol, pos_eol, pos_sof, pos_eof;

    line_pos_cnt #(
        .WORD_BYTES  (WORD_BYTES),
        .LINE_BYTES  (LINE_BYTES),
        .FRAME_LINES (FRAME_LINES)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start_ok),
        .adv_i (load),
        .sol_o (pos_sol),
        .eol_o (pos_eol),
        .sof_o (pos_sof),
        .eof_o (pos_eof)
    );

    // Pop/pack/load decisions, FSM transitions and starvation tracking.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        pack_d       = pack_q;
        data_d       = data_q;
        valid_d      = valid_q;
        sol_d        = sol_q;
        eol_d        = eol_q;
        sof_d        = sof_q;
        eof_d        = eof_q;
        done_d       = 1'b0;
        starve_cnt_d = starve_cnt_q;
        starve_err_d = starve_err_q;

        start_ok = (state_q == IDLE) && start && !abort;
        accept   = valid_q && out_ready;
        // A pending eof word means the frame's last byte is already consumed.
        pop      = (state_q == RUN) && !fifo_empty && !abort && !(valid_q && eof_q) &&
                   ((slot_q != SLOT_LAST) || !valid_q || out_ready);
        load     = pop && (slot_q == SLOT_LAST);
        mid_line = (slot_q != '0) || !pos_sol;

        if (abort) begin
            state_d = IDLE;
        end else if (start_ok) begin
            state_d = RUN;
        end else if ((state_q == RUN) && accept && eof_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end

        if (start_ok) begin
            slot_d = '0;
        end else if (pop) begin
            if (load) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + SW'(1);
                pack_d[int'(slot_q)*8 +: 8] = fifo_dout;
            end
        end

        if (abort) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = pack_q;
            data_d[8*(WORD_BYTES-1) +: 8] = fifo_dout;
            sol_d   = pos_sol;
            eol_d   = pos_eol;
            sof_d   = pos_sof;
            eof_d   = pos_eof;
        end else if (accept) begin
            valid_d = 1'b0;
        end

        if (start_ok || abort || pop) begin
            starve_cnt_d = '0;
        end else if ((state_q == RUN) && fifo_empty && mid_line &&
                     (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
            if (starve_cnt_d == STARVE_MAX) begin
                starve_err_d = 1'b1;
            end
        end
        if (start_ok) begin
            starve_err_d = 1'b0;
        end
    end

    // State, pack and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            pack_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            sol_q        <= 1'b0;
            eol_q        <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            done_q       <= 1'b0;
            starve_cnt_q <= '0;
            starve_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            pack_q       <= pack_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            sol_q        <= sol_d;
            eol_q        <= eol_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            done_q       <= done_d;
            starve_cnt_q <= starve_cnt_d;
            starve_err_q <= starve_err_d;
        end
    end

    assign fifo_rd_en = pop;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_sol    = sol_q;
    assign out_eol    = eol_q;
    assign out_sof    = sof_q;
    assign out_eof    = eof_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign starve_err = starve_err_q;

endmodule

// File: tb/tb_line_packer.sv
// Scoreboard bench for line_packer: 8-byte lines, 2-line frames, 4-byte words.
module tb_line_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sol, out_eol, out_sof, out_eof;
    logic        busy, done, starve_err;

    int total = 0;
    int bad = 0;

    line_packer #(
        .WORD_BYTES  (4),
        .LINE_BYTES  (8),
        .FRAME_LINES (2),
        .STARVE_CYC  (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .busy       (busy),
        .done       (done),
        .starve_err (starve_err)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [7:0] mem [256];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    logic       fifo_flush = 1'b0;
    int         pop_cnt = 0;

    assign fifo_dout  = mem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    typedef struct packed {
        logic [31:0] d;
        logic        sol, eol, sof, eof;
    } exp_t;

    exp_t exp_q[$];
    int   done_cnt = 0;
    int   acc_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: compare each presented word against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (fifo_rd_en) chk("pop_while_empty", fifo_empty, 1'b0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk(out_ready ? "word_data" : "held_data", out_data, exp_q[0].d);
                    chk(out_ready ? "word_tags" : "held_tags",
                        {out_sol, out_eol, out_sof, out_eof},
                        {exp_q[0].sol, exp_q[0].eol, exp_q[0].sof, exp_q[0].eof});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 8'(i);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic push_word(input logic [7:0] b, input int k);
        exp_t e;
        e.d   = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        e.sol = (k % 2) == 0;
        e.eol = (k % 2) == 1;
        e.sof = (k == 0);
        e.eof = (k == 3);
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int k = 0; k < 4; k++) push_word(base + 8'(4 * k), k);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk(nm, done_cnt - d0, 1);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pop_cnt < target && n < budget) begin
            tick();
            n++;
        end
    endtask

    int p0, p1, a0, n;

    initial begin
        tick();
        tick();
        chk("reset_outputs",
            {out_data, out_valid, out_sol, out_eol, out_sof, out_eof, busy, done, starve_err, fifo_rd_en},
            '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {busy, out_valid, fifo_rd_en}, 3'b000);

        // 1: plain frame
        load_bytes(8'h00, 16);
        push_frame(8'h00);
        p0 = pop_cnt;
        pulse_start();
        wait_done("t1_done_once", 100);
        chk("t1_pops", pop_cnt - p0, 16);
        chk("t1_words_left", exp_q.size(), 0);
        chk("t1_idle", busy, 1'b0);

        // 2: backpressure on word 2
        load_bytes(8'h10, 16);
        push_frame(8'h10);
        p0 = pop_cnt;
        a0 = acc_cnt;
        pulse_start();
        n = 0;
        while (acc_cnt < a0 + 1 && n < 50) begin tick(); n++; end
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        p1 = pop_cnt;
        repeat (5) tick();
        chk("t2_stall_pops_le3", (pop_cnt - p1) <= 3, 1'b1);
        out_ready = 1'b1;
        wait_done("t2_done_once", 100);
        chk("t2_pops", pop_cnt - p0, 16);
        chk("t2_words_left", exp_q.size(), 0);

        // 3: mid-line starvation
        load_bytes(8'h20, 2);
        push_frame(8'h20);
        p0 = pop_cnt;
        pulse_start();
        wait_pops(p0 + 2, 20);
        repeat (1023) tick();
        chk("t3_err_before_1024", starve_err, 1'b0);
        tick();
        chk("t3_err_at_1024", starve_err, 1'b1);
        repeat (976) tick();
        chk("t3_err_sticky_empty", starve_err, 1'b1);
        load_bytes(8'h22, 14);
        wait_done("t3_done_once", 100);
        chk("t3_err_sticky_done", starve_err, 1'b1);
        chk("t3_pops", pop_cnt - p0, 16);
        load_bytes(8'h30, 8);
        push_frame(8'h30);
        p0 = pop_cnt;
        pulse_start();
        chk("t3_start_clears_err", starve_err, 1'b0);
        wait_pops(p0 + 8, 50);
        repeat (1100) tick();
        chk("t3_line_boundary_no_err", starve_err, 1'b0);
        load_bytes(8'h38, 8);
        wait_done("t3b_done_once", 100);
        chk("t3b_words_left", exp_q.size(), 0);

        // 4: abort with a held word
        out_ready = 1'b0;
        load_bytes(8'h40, 16);
        push_word(8'h40, 0);
        p0 = pop_cnt;
        pulse_start();
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_state", {busy, out_valid, fifo_rd_en}, 3'b000);
        tick();
        chk("t4_abort_pops", pop_cnt - p0, 7);
        exp_q.delete();
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
        out_ready = 1'b1;
        load_bytes(8'h50, 16);
        push_frame(8'h50);
        p0 = pop_cnt;
        pulse_start();
        wait_done("t4_restart_done", 100);
        chk("t4_restart_pops", pop_cnt - p0, 16);
        chk("t4_words_left", exp_q.size(), 0);

        // 5: start+abort together, start while running
        load_bytes(8'h60, 16);
        p0 = pop_cnt;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_start_abort_idle", busy, 1'b0);
        repeat (3) tick();
        chk("t5_start_abort_no_pop", pop_cnt - p0, 0);
        push_frame(8'h60);
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_done("t5_done_once", 100);
        chk("t5_pops", pop_cnt - p0, 16);
        chk("t5_words_left", exp_q.size(), 0);

        // 6: asynchronous reset mid-frame
        load_bytes(8'h70, 16);
        push_frame(8'h70);
        a0 = acc_cnt;
        pulse_start();
        n = 0;
        while (acc_cnt < a0 + 1 && n < 50) begin tick(); n++; end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs",
            {out_data, out_valid, out_sol, out_eol, out_sof, out_eof, busy, done, starve_err, fifo_rd_en},
            '0);
        exp_q.delete();
        p0 = pop_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_pop_after_reset", {fifo_rd_en, busy}, 2'b00);
        end
        chk("t6_pops_frozen", pop_cnt - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
